// File: rtl/ucsbece154b_issue_hazard_unit_pkg.sv
// Shared definitions for the N-lane issue/hazard unit.
// Holds the forward-select encoding, the load ResultSrc code and width helpers.
// Combinational helpers only; no state.
package ucsbece154b_issue_hazard_unit_pkg;

  // ResultSrc value that marks a load (lw) in the controller.
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Forward select: 0 reads the register file.
  localparam int FORWARD_EX = 0;

  // M stage lane l forwards with code 1 + l.
  function automatic int forward_mem(input int lanes, input int l);
    return 1 + 0 * lanes + l;
  endfunction

  // W stage lane l forwards with code 1 + LANES + l.
  function automatic int forward_wb(input int lanes, input int l);
    return 1 + lanes + l;
  endfunction

  // Width of one lane's forward select: codes run 0..2*LANES.
  function automatic int fwd_width(input int lanes);
    return $clog2(2 * lanes + 1);
  endfunction

  // Width of the issue pointer; at least one bit so LANES=1 still elaborates.
  function automatic int base_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/ucsbece154b_issue_hazard_unit_fwd_select.sv
// One operand's forward select: picks the youngest M writer, else the youngest W writer.
// Latency: combinational, 0 cycles.
// Backpressure: none; M and W never stall.
// Ports: en (E lane valid), rs (source reg), m_rd/m_rw and w_rd/w_rw (per-lane
// destination and write enable of the M and W stages), sel (forward code).
module ucsbece154b_fwd_select
  import ucsbece154b_issue_hazard_unit_pkg::*;
#(
  parameter int LANES = 2,
  parameter int REGW  = 5,
  parameter int FW    = 3
) (
  input  logic                        en,
  input  logic [REGW-1:0]             rs,
  input  logic [LANES-1:0][REGW-1:0]  m_rd,
  input  logic [LANES-1:0]            m_rw,
  input  logic [LANES-1:0][REGW-1:0]  w_rd,
  input  logic [LANES-1:0]            w_rw,
  output logic [FW-1:0]               sel
);

  // Later assignments win: W lanes ascending, then M lanes ascending, so the
  // result is the highest matching M lane, else the highest matching W lane.
  always_comb begin
    sel = FW'(FORWARD_EX);
    if (en && rs != '0) begin
      for (int l = 0; l < LANES; l++)
        if (w_rw[l] && w_rd[l] == rs) sel = FW'(forward_wb(LANES, l));
      for (int l = 0; l < LANES; l++)
        if (m_rw[l] && m_rd[l] == rs) sel = FW'(forward_mem(LANES, l));
    end
  end

endmodule

// File: rtl/ucsbece154b_issue_hazard_unit.sv
// Hazard/forwarding unit for an N-lane in-order pipeline with its own E/M/W scoreboard.
// Latency: all outputs combinational from state and inputs (0 cycles).
// Backpressure: stalls F/D on load-use or intra-bundle dependency; issues the bundle in pieces.
// Ports: D-stage lane fields in (ValidD/Rs1D/Rs2D/RdD/RegWriteD/LoadD), per-lane
// MisspredictE in; stall/flush controls, per-lane IssueD and ForwardAE/BE selects out.
module ucsbece154b_issue_hazard_unit
  import ucsbece154b_issue_hazard_unit_pkg::*;
#(
  parameter  int LANES = 2,
  parameter  int REGW  = 5,
  localparam int FW    = fwd_width(LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      ValidD_i,
  input  logic [LANES*REGW-1:0] Rs1D_i,
  input  logic [LANES*REGW-1:0] Rs2D_i,
  input  logic [LANES*REGW-1:0] RdD_i,
  input  logic [LANES-1:0]      RegWriteD_i,
  input  logic [LANES-1:0]      LoadD_i,
  input  logic [LANES-1:0]      MisspredictE_i,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  FlushD_o,
  output logic [LANES-1:0]      FlushE_o,
  output logic [LANES-1:0]      FlushM_o,
  output logic [LANES-1:0]      IssueD_o,
  output logic [LANES*FW-1:0]   ForwardAE_o,
  output logic [LANES*FW-1:0]   ForwardBE_o
);

  localparam int BW = base_width(LANES);

  logic [LANES-1:0][REGW-1:0] rs1_d, rs2_d, rd_d;
  assign rs1_d = Rs1D_i;
  assign rs2_d = Rs2D_i;
  assign rd_d  = RdD_i;

  // Issue pointer: first lane of the current bundle not yet sent to E.
  logic [BW-1:0] base_q, base_d;

  logic [LANES-1:0]           e_vld_q, e_vld_d, e_rw_q, e_rw_d, e_ld_q, e_ld_d;
  logic [LANES-1:0][REGW-1:0] e_rd_q, e_rd_d, e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
  logic [LANES-1:0][REGW-1:0] m_rd_q, m_rd_d, w_rd_q, w_rd_d;
  logic [LANES-1:0]           m_rw_q, m_rw_d, w_rw_q, w_rw_d;

  logic [LANES-1:0] hz, issue, flush_m, seen_misp;
  logic             stall, misp;
  int               blk;

  // Per-lane hazard: load-use against any E load, or a RAW on an older
  // candidate lane of the same bundle.
  always_comb begin
    hz = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int e = 0; e < LANES; e++)
        if (e_vld_q[e] && e_ld_q[e] && e_rd_q[e] != '0 &&
            (e_rd_q[e] == rs1_d[j] || e_rd_q[e] == rs2_d[j]))
          hz[j] = 1'b1;
      if (j > int'(base_q) && ValidD_i[j])
        for (int i = 0; i < j; i++)
          if (i >= int'(base_q) && ValidD_i[i] && RegWriteD_i[i] && rd_d[i] != '0 &&
              (rd_d[i] == rs1_d[j] || rd_d[i] == rs2_d[j]))
            hz[j] = 1'b1;
    end
  end

  // Block lane, issue mask and mispredict override.
  always_comb begin
    blk = LANES;
    for (int j = LANES - 1; j >= 0; j--)
      if (j >= int'(base_q) && hz[j]) blk = j;
    for (int l = 0; l < LANES; l++)
      issue[l] = (l >= int'(base_q)) && (l < blk) && ValidD_i[l];
    stall = (blk < LANES);

    // Lanes younger than the oldest mispredicting lane are squashed into M.
    misp      = |MisspredictE_i;
    seen_misp = '0;
    flush_m   = '0;
    for (int l = 0; l < LANES; l++) begin
      flush_m[l] = (l > 0) ? seen_misp[l-1] : 1'b0;
      seen_misp[l] = MisspredictE_i[l] | flush_m[l];
    end
    if (misp) begin
      issue = '0;
      stall = 1'b0;
    end
    base_d = stall ? BW'(blk) : '0;
  end

  // Scoreboard advance: D->E per issued lane, E->M unless squashed, M->W always.
  always_comb begin
    e_vld_d = issue;
    e_rw_d  = issue & RegWriteD_i;
    e_ld_d  = issue & LoadD_i;
    for (int l = 0; l < LANES; l++) begin
      e_rd_d[l]  = issue[l] ? rd_d[l]  : '0;
      e_rs1_d[l] = issue[l] ? rs1_d[l] : '0;
      e_rs2_d[l] = issue[l] ? rs2_d[l] : '0;
    end
    m_rd_d = e_rd_q;
    m_rw_d = e_rw_q & e_vld_q & ~flush_m;
    w_rd_d = m_rd_q;
    w_rw_d = m_rw_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      e_vld_q <= '0;
      e_rw_q  <= '0;
      e_ld_q  <= '0;
      e_rd_q  <= '0;
      e_rs1_q <= '0;
      e_rs2_q <= '0;
      m_rd_q  <= '0;
      m_rw_q  <= '0;
      w_rd_q  <= '0;
      w_rw_q  <= '0;
    end else begin
      base_q  <= base_d;
      e_vld_q <= e_vld_d;
      e_rw_q  <= e_rw_d;
      e_ld_q  <= e_ld_d;
      e_rd_q  <= e_rd_d;
      e_rs1_q <= e_rs1_d;
      e_rs2_q <= e_rs2_d;
      m_rd_q  <= m_rd_d;
      m_rw_q  <= m_rw_d;
      w_rd_q  <= w_rd_d;
      w_rw_q  <= w_rw_d;
    end
  end

  logic [LANES-1:0][FW-1:0] fwd_a, fwd_b;

  for (genvar l = 0; l < LANES; l++) begin : g_fwd
    ucsbece154b_fwd_select #(.LANES(LANES), .REGW(REGW), .FW(FW)) u_fwd_a (
      .en   (e_vld_q[l]),
      .rs   (e_rs1_q[l]),
      .m_rd (m_rd_q),
      .m_rw (m_rw_q),
      .w_rd (w_rd_q),
      .w_rw (w_rw_q),
      .sel  (fwd_a[l])
    );
    ucsbece154b_fwd_select #(.LANES(LANES), .REGW(REGW), .FW(FW)) u_fwd_b (
      .en   (e_vld_q[l]),
      .rs   (e_rs2_q[l]),
      .m_rd (m_rd_q),
      .m_rw (m_rw_q),
      .w_rd (w_rd_q),
      .w_rw (w_rw_q),
      .sel  (fwd_b[l])
    );
  end

  // Every output reads 0 while reset is held.
  assign StallF_o    = !reset && stall;
  assign StallD_o    = !reset && stall;
  assign FlushD_o    = !reset && misp;
  assign FlushE_o    = reset ? '0 : ~issue;
  assign FlushM_o    = reset ? '0 : flush_m;
  assign IssueD_o    = reset ? '0 : issue;
  assign ForwardAE_o = reset ? '0 : fwd_a;
  assign ForwardBE_o = reset ? '0 : fwd_b;

endmodule

// File: tb/tb_ucsbece154b_issue_hazard_unit.sv
module tb_ucsbece154b_issue_hazard_unit;

  localparam int L  = 2;
  localparam int RW = 5;
  localparam int FW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [L-1:0]    ValidD_i, RegWriteD_i, LoadD_i, MisspredictE_i;
  logic [L*RW-1:0] Rs1D_i, Rs2D_i, RdD_i;
  logic            StallF_o, StallD_o, FlushD_o;
  logic [L-1:0]    FlushE_o, FlushM_o, IssueD_o;
  logic [L*FW-1:0] ForwardAE_o, ForwardBE_o;

  ucsbece154b_issue_hazard_unit #(.LANES(L), .REGW(RW)) dut (
    .clk(clk), .reset(reset),
    .ValidD_i(ValidD_i), .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .RdD_i(RdD_i),
    .RegWriteD_i(RegWriteD_i), .LoadD_i(LoadD_i), .MisspredictE_i(MisspredictE_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .FlushD_o(FlushD_o),
    .FlushE_o(FlushE_o), .FlushM_o(FlushM_o), .IssueD_o(IssueD_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // D-stage stimulus, one entry per lane
  int d_v[L], d_rs1[L], d_rs2[L], d_rd[L], d_rw[L], d_ld[L], d_mp[L];

  // Reference scoreboard: instruction records per stage
  int e_v[L], e_rd[L], e_rs1[L], e_rs2[L], e_rw[L], e_ld[L];
  int m_rd[L], m_rw[L], w_rd[L], w_rw[L];
  int base_m, nb_m;

  logic [L-1:0]    x_issue, x_fe, x_fm;
  logic            x_stall, x_fd;
  logic [L*FW-1:0] x_fa, x_fb;

  task automatic apply();
    for (int l = 0; l < L; l++) begin
      ValidD_i[l]          = (d_v[l] != 0);
      RegWriteD_i[l]       = (d_rw[l] != 0);
      LoadD_i[l]           = (d_ld[l] != 0);
      MisspredictE_i[l]    = (d_mp[l] != 0);
      Rs1D_i[l*RW +: RW]   = RW'(d_rs1[l]);
      Rs2D_i[l*RW +: RW]   = RW'(d_rs2[l]);
      RdD_i[l*RW +: RW]    = RW'(d_rd[l]);
    end
  endtask

  task automatic set_idle();
    for (int l = 0; l < L; l++) begin
      d_v[l] = 0; d_rs1[l] = 0; d_rs2[l] = 0; d_rd[l] = 0;
      d_rw[l] = 0; d_ld[l] = 0; d_mp[l] = 0;
    end
  endtask

  task automatic set_lane(input int l, input int rd, input int rs1, input int rs2,
                          input int rw, input int ld);
    d_v[l] = 1; d_rd[l] = rd; d_rs1[l] = rs1; d_rs2[l] = rs2; d_rw[l] = rw; d_ld[l] = ld;
  endtask

  task automatic model_reset();
    for (int l = 0; l < L; l++) begin
      e_v[l] = 0; e_rd[l] = 0; e_rs1[l] = 0; e_rs2[l] = 0; e_rw[l] = 0; e_ld[l] = 0;
      m_rd[l] = 0; m_rw[l] = 0; w_rd[l] = 0; w_rw[l] = 0;
    end
    base_m = 0;
  endtask

  // Youngest in-flight producer of rs: M stage first, highest lane first.
  function automatic int src(input int rs);
    if (rs == 0) return 0;
    for (int l = L - 1; l >= 0; l--) if (m_rw[l] != 0 && m_rd[l] == rs) return 1 + l;
    for (int l = L - 1; l >= 0; l--) if (w_rw[l] != 0 && w_rd[l] == rs) return 1 + L + l;
    return 0;
  endfunction

  task automatic model_eval();
    int blk, k;
    bit hzd;
    blk = L;
    for (int j = base_m; j < L; j++) begin
      hzd = 0;
      for (int e = 0; e < L; e++)
        if (e_v[e] != 0 && e_ld[e] != 0 && e_rd[e] != 0 &&
            (e_rd[e] == d_rs1[j] || e_rd[e] == d_rs2[j])) hzd = 1;
      if (j > base_m && d_v[j] != 0)
        for (int i = base_m; i < j; i++)
          if (d_v[i] != 0 && d_rw[i] != 0 && d_rd[i] != 0 &&
              (d_rd[i] == d_rs1[j] || d_rd[i] == d_rs2[j])) hzd = 1;
      if (hzd && blk == L) blk = j;
    end
    x_issue = '0;
    for (int l = 0; l < L; l++)
      if (l >= base_m && l < blk && d_v[l] != 0) x_issue[l] = 1'b1;
    x_stall = (blk < L);
    k = -1;
    for (int l = L - 1; l >= 0; l--) if (d_mp[l] != 0) k = l;
    x_fm = '0;
    x_fd = 1'b0;
    if (k >= 0) begin
      x_fd = 1'b1;
      x_issue = '0;
      x_stall = 1'b0;
      for (int l = k + 1; l < L; l++) x_fm[l] = 1'b1;
    end
    x_fe = ~x_issue;
    nb_m = x_stall ? blk : 0;
    for (int l = 0; l < L; l++) begin
      x_fa[l*FW +: FW] = (e_v[l] != 0) ? FW'(src(e_rs1[l])) : '0;
      x_fb[l*FW +: FW] = (e_v[l] != 0) ? FW'(src(e_rs2[l])) : '0;
    end
  endtask

  task automatic model_step();
    for (int l = 0; l < L; l++) begin
      w_rd[l] = m_rd[l];
      w_rw[l] = m_rw[l];
      m_rd[l] = e_rd[l];
      m_rw[l] = (e_v[l] != 0 && e_rw[l] != 0 && !x_fm[l]) ? 1 : 0;
      e_v[l]   = x_issue[l] ? 1 : 0;
      e_rd[l]  = x_issue[l] ? d_rd[l]  : 0;
      e_rs1[l] = x_issue[l] ? d_rs1[l] : 0;
      e_rs2[l] = x_issue[l] ? d_rs2[l] : 0;
      e_rw[l]  = x_issue[l] ? d_rw[l]  : 0;
      e_ld[l]  = x_issue[l] ? d_ld[l]  : 0;
    end
    base_m = nb_m;
  endtask

  // Called one time unit after a rising edge; compares at the falling edge.
  task automatic cycle_begin();
    apply();
    @(negedge clk);
    model_eval();
    chk("StallF", StallF_o, x_stall);
    chk("StallD", StallD_o, x_stall);
    chk("FlushD", FlushD_o, x_fd);
    chk("FlushE", FlushE_o, x_fe);
    chk("FlushM", FlushM_o, x_fm);
    chk("IssueD", IssueD_o, x_issue);
    chk("FwdA", ForwardAE_o, x_fa);
    chk("FwdB", ForwardBE_o, x_fb);
  endtask

  task automatic cycle_end();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cycle_begin();
    cycle_end();
  endtask

  task automatic settle();
    set_idle();
    step();
  endtask

  task automatic fwd_case(input int m1rw, input int rs, input int expct);
    settle();
    set_lane(0, 5, 0, 0, 1, 0); set_lane(1, 5, 0, 0, 1, 0); step();
    set_lane(0, 5, 0, 0, 1, 0); set_lane(1, 5, 0, 0, m1rw, 0); step();
    set_idle(); set_lane(0, 1, rs, 0, 1, 0); step();
    set_idle(); cycle_begin();
    chk("fwd_prio", ForwardAE_o[FW-1:0], expct);
    cycle_end();
  endtask

  task automatic load_setup();
    settle();
    set_lane(0, 1, 0, 0, 1, 0); set_lane(1, 7, 0, 0, 1, 1); step();
    set_idle(); set_lane(0, 2, 7, 0, 1, 0); set_lane(1, 3, 0, 0, 1, 0);
  endtask

  task automatic split_bundle();
    set_idle(); set_lane(0, 3, 1, 0, 1, 0); set_lane(1, 4, 3, 1, 1, 0);
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {StallF_o, StallD_o, FlushD_o, FlushE_o, FlushM_o, IssueD_o,
                       ForwardAE_o, ForwardBE_o}, 32'd0);
    reset = 1'b0;
    cycle_begin();
    chk("idle_issue", IssueD_o, 2'b00);
    chk("idle_flushe", FlushE_o, 2'b11);
    cycle_end();

    fwd_case(1, 5, 2);
    fwd_case(0, 5, 1);
    fwd_case(1, 0, 0);

    // Intra-bundle split, then the same bundle again from base 0
    settle();
    split_bundle();
    cycle_begin();
    chk("split1_issue", IssueD_o, 2'b01);
    chk("split1_fe", FlushE_o, 2'b10);
    chk("split1_stall", {StallF_o, StallD_o}, 2'b11);
    cycle_end();
    cycle_begin();
    chk("split2_issue", IssueD_o, 2'b10);
    chk("split2_fe", FlushE_o, 2'b01);
    chk("split2_stall", {StallF_o, StallD_o}, 2'b00);
    cycle_end();
    cycle_begin();
    chk("split3_issue", IssueD_o, 2'b01);
    cycle_end();

    // Load-use
    load_setup();
    cycle_begin();
    chk("lu1_issue", IssueD_o, 2'b00);
    chk("lu1_fe", FlushE_o, 2'b11);
    chk("lu1_stall", StallF_o, 1'b1);
    cycle_end();
    cycle_begin();
    chk("lu2_issue", IssueD_o, 2'b11);
    cycle_end();
    set_idle();
    cycle_begin();
    chk("lu3_fwd", ForwardAE_o[FW-1:0], 3'd4);
    cycle_end();

    // Mispredict in the middle of a split
    settle();
    split_bundle();
    step();
    d_mp[0] = 1;
    cycle_begin();
    chk("mp_fd", FlushD_o, 1'b1);
    chk("mp_fe", FlushE_o, 2'b11);
    chk("mp_fm", FlushM_o, 2'b10);
    chk("mp_stall", StallF_o, 1'b0);
    cycle_end();
    d_mp[0] = 0;
    cycle_begin();
    chk("mp_base0", IssueD_o, 2'b01);
    cycle_end();

    // Load-use and mispredict together
    load_setup();
    d_mp[1] = 1;
    cycle_begin();
    chk("mplu_fm", FlushM_o, 2'b00);
    chk("mplu_fd", FlushD_o, 1'b1);
    chk("mplu_stall", StallF_o, 1'b0);
    cycle_end();

    // Asynchronous reset asserted mid-cycle with live inputs
    set_idle(); set_lane(0, 1, 0, 0, 1, 0); set_lane(1, 2, 0, 0, 1, 0);
    apply();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", {StallF_o, StallD_o, FlushD_o, FlushE_o, FlushM_o, IssueD_o,
                      ForwardAE_o, ForwardBE_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    set_idle();
    cycle_begin();
    chk("rst_idle_issue", IssueD_o, 2'b00);
    chk("rst_idle_fe", FlushE_o, 2'b11);
    cycle_end();

    // Randomized traffic with small register range to provoke hazards
    repeat (500) begin
      for (int l = 0; l < L; l++) begin
        d_v[l]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
        d_rs1[l] = $urandom_range(0, 7);
        d_rs2[l] = $urandom_range(0, 7);
        d_rd[l]  = $urandom_range(0, 7);
        d_rw[l]  = ($urandom_range(0, 9) < 7) ? 1 : 0;
        d_ld[l]  = ($urandom_range(0, 9) < 3) ? 1 : 0;
        d_mp[l]  = ($urandom_range(0, 15) == 0) ? 1 : 0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
